icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Sequencing controller for the instruction cache: accepts fetch requests, drives the lookup address into the tag array and data RAM, resolves hit/miss one cycle later, and on a miss runs an 8-beat line refill from memory. It then writes the data words and the tag and returns the requested word. It sits between the fetch stage and the tag/data RAMs plus the memory read port, and holds fetch off until the tag array's post-reset clearing sweep reports done.

## Interface
Parameters
- LINE_WORDS, 8, words per line (32-byte line, index addr[11:5], word offset addr[4:2])
- TAG_W, 20, tag width (addr[31:12])

Ports
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, `rst`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  fetch request
- req_addr  in  32  fetch address (word aligned)
- req_ready  out  1  request accepted when req_valid&req_ready
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  instruction word
- tag_work  in  1  tag array clear sweep finished
- tag_pre_addr  out  32  lookup address to tag array (registered read, result next cycle)
- tag_addr  out  32  write-index address to tag array
- tag_wen  out  4  tag write enable (4'hF or 0)
- tag_wdata  out  21  {valid, tag}
- tag_hit  in  1  tag compare result for previous cycle's tag_pre_addr
- tag_valid  in  1  valid bit of that entry
- data_addr  out  10  data RAM word address {index, offset}
- data_wen  out  1  data RAM write
- data_wdata  out  32  data RAM write data
- data_rdata  in  32  data RAM read data, 1-cycle latency
- mem_req  out  1  line read request
- mem_addr  out  32  line base {addr[31:5], 5'b0}
- mem_gnt  in  1  address accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data
- mem_rlast  in  1  final beat

## Operation
- States: INIT, IDLE, LOOKUP, MISS_REQ, REFILL, TAG_WR, DONE.
- INIT: req_ready=0; advance to IDLE on first cycle tag_work=1.
- IDLE: req_ready=1; on accept, latch req_addr into addr_q; tag_pre_addr and data_addr come combinationally from req_addr in the accept cycle; go to LOOKUP.
- LOOKUP: hit = tag_hit&tag_valid.
  - Hit: resp_valid=1, resp_data=data_rdata. req_ready=1, and a new request may be accepted in the same cycle (back-to-back hits); stay in LOOKUP if accepted, else go to IDLE.
  - Miss: req_ready=0; go to MISS_REQ.
- MISS_REQ: mem_req=1, mem_addr=line base of addr_q, held stable until mem_gnt; on mem_gnt go to REFILL with beat counter cnt=0.
- REFILL: each mem_rvalid writes data RAM at {addr_q[11:5],cnt} with mem_rdata and increments cnt (3-bit, wraps). Capture mem_rdata into crit_q when cnt==addr_q[4:2]. mem_rlast together with mem_rvalid goes to TAG_WR. mem_rlast ends the refill regardless of cnt.
- TAG_WR: tag_wen=4'hF, tag_addr=addr_q, tag_wdata={1'b1,addr_q[31:12]}; go to DONE.
- DONE: resp_valid=1, resp_data=crit_q; go to IDLE. No request accepted in DONE.
- mem_rvalid outside REFILL is ignored. tag_wen and data_wen are 0 outside TAG_WR and REFILL respectively.

## Timing
- Reset values: state=INIT, req_ready=0, resp_valid=0, resp_data=0, mem_req=0, mem_addr=0, tag_wen=0, tag_wdata=0, data_wen=0, cnt=0, addr_q=0, crit_q=0.
- Hit latency: request accepted at cycle N -> resp_valid at N+1. Sustained throughput is 1 per cycle on hits.
- Miss latency: accepted at N; LOOKUP N+1; mem_req from N+2; after the gnt cycle G, 8 beats; last beat at cycle L; TAG_WR L+1; resp_valid L+2.
- A tag write at TAG_WR is visible to a lookup accepted in DONE+1 or later.
- rst mid-refill returns to INIT at the next edge. Remaining memory beats are dropped, and the line is not tagged valid.
- tag_work falling after INIT is not monitored.

## Test plan
- Reset, tag_work held 0 for 130 cycles -> req_ready=0 throughout; tag_work=1 -> req_ready=1 next cycle.
- Cold miss at 0xBFC0_0014 -> mem_addr=0xBFC0_0000. Beats 0x100..0x107 -> data writes at index 0x00, offsets 0..7. tag_wdata=0x1BFC00 with tag_wen=4'hF. resp_data=0x105 at L+2.
- Repeat 0xBFC0_0014 after refill -> hit, resp_valid one cycle after accept, no mem_req.
- Back-to-back hits 0xBFC0_0000, 0xBFC0_0004, 0xBFC0_0008 on consecutive cycles -> three consecutive resp_valid pulses with the correct words.
- Conflict miss at 0xBFC0_1000 (same index, new tag) -> refill; tag rewritten to 0x1BFC01. A following lookup of 0xBFC0_0000 misses.
- rst asserted after 3 refill beats -> INIT; tag not written; next lookup of the same line misses.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache sequencing controller: lookup, hit/miss resolution,
// 8-beat line refill from memory, tag write and critical-word return.
module icache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned TAG_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  input  logic             tag_work,
  output logic [31:0]      tag_pre_addr,
  output logic [31:0]      tag_addr,
  output logic [3:0]       tag_wen,
  output logic [TAG_W:0]   tag_wdata,
  input  logic             tag_hit,
  input  logic             tag_valid,
  output logic [9:0]       data_addr,
  output logic             data_wen,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rlast
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_LSB = OFF_W + 2;
  localparam int unsigned DADDR_W = 10;
  localparam int unsigned IDX_W   = DADDR_W - OFF_W;
  localparam int unsigned IDX_MSB = IDX_LSB + IDX_W - 1;
  localparam int unsigned TAG_LSB = 32 - TAG_W;

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_LOOKUP   = 3'd2;
  localparam logic [2:0] S_MISS_REQ = 3'd3;
  localparam logic [2:0] S_REFILL   = 3'd4;
  localparam logic [2:0] S_TAG_WR   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      crit_q, crit_d;
  logic             hit;

  assign hit = tag_hit & tag_valid;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      addr_q  <= '0;
      cnt_q   <= '0;
      crit_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      crit_q  <= crit_d;
    end
  end

  // Next-state and output decode; RAM addresses are combinational so a
  // lookup issued in the accept cycle resolves in the following cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    crit_d       = crit_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_data    = '0;
    tag_pre_addr = req_addr;
    tag_addr     = addr_q;
    tag_wen      = 4'h0;
    tag_wdata    = '0;
    data_addr    = req_addr[IDX_MSB:2];
    data_wen     = 1'b0;
    data_wdata   = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;

    case (state_q)
      S_INIT: begin
        if (tag_work) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_data  = data_rdata;
          req_ready  = 1'b1;
          if (req_valid) begin
            addr_d  = req_addr;
            state_d = S_LOOKUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        data_addr = {addr_q[IDX_MSB:IDX_LSB], cnt_q};
        if (mem_rvalid) begin
          data_wen   = 1'b1;
          data_wdata = mem_rdata;
          cnt_d      = cnt_q + OFF_W'(1);
          if (cnt_q == addr_q[IDX_LSB-1:2]) crit_d = mem_rdata;
          if (mem_rlast) state_d = S_TAG_WR;
        end
      end
      S_TAG_WR: begin
        tag_wen   = 4'hF;
        tag_wdata = {1'b1, addr_q[31:TAG_LSB]};
        state_d   = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_data  = crit_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench: tag/data RAM and memory models around the controller,
// with a transaction-level cache model predicting every observable output.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_data;
  logic        tag_work = 1'b0;
  logic [31:0] tag_pre_addr, tag_addr;
  logic [3:0]  tag_wen;
  logic [20:0] tag_wdata;
  logic        tag_hit = 1'b0, tag_valid = 1'b0;
  logic [9:0]  data_addr;
  logic        data_wen;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_rlast = 1'b0;
  logic [31:0] mem_rdata = '0;

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .tag_work(tag_work), .tag_pre_addr(tag_pre_addr), .tag_addr(tag_addr),
    .tag_wen(tag_wen), .tag_wdata(tag_wdata), .tag_hit(tag_hit),
    .tag_valid(tag_valid), .data_addr(data_addr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Backing memory contents; the boot line holds 0x100..0x107
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h5FE0000) return 32'h100 + {29'b0, a[4:2]};
    return (a * 32'h9E3779B1) ^ 32'hA5C3_0F17;
  endfunction

  // Tag array and data RAM: registered reads, contents survive rst
  logic [20:0] tram [128] = '{default: '0};
  logic [31:0] dram [1024] = '{default: '0};
  always @(posedge clk) begin
    if (tag_wen == 4'hF) tram[tag_addr[11:5]] <= tag_wdata;
    tag_valid  <= tram[tag_pre_addr[11:5]][20];
    tag_hit    <= (tram[tag_pre_addr[11:5]][19:0] == tag_pre_addr[31:12]);
    if (data_wen) dram[data_addr] <= data_wdata;
    data_rdata <= dram[data_addr];
  end

  // Memory read port: random grant delay, random beat gaps, junk beats when idle
  int beat_limit = 8;
  initial begin : mem_drv
    int phase, dly, k;
    logic [31:0] line;
    logic r;
    phase = 0; dly = 0; k = 0; line = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = $urandom;
      if (r) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (mem_req) begin
              line  = mem_addr;
              dly   = $urandom_range(0, 2);
              phase = 1;
            end else if ($urandom_range(0, 3) == 0) begin
              mem_rvalid = 1'b1;
              mem_rlast  = 1'($urandom_range(0, 1));
            end
          end
          1: begin
            if (dly == 0) begin
              mem_gnt = 1'b1; phase = 2; k = 0;
            end else dly--;
          end
          default: begin
            if (k < beat_limit && $urandom_range(0, 3) != 0) begin
              mem_rvalid = 1'b1;
              mem_rdata  = mem_word(line + 32'(k * 4));
              mem_rlast  = (k == 7);
              k++;
              if (k == 8) phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Transaction-level cache model and per-cycle comparison
  bit          cv [128] = '{default: 1'b0};
  logic [19:0] ct [128] = '{default: '0};
  bit          init_done = 0, busy = 0, miss_on = 0, gnt_done = 0, refill_on = 0;
  bit          prev_rst = 1;
  int          miss_cyc = 0, tagwr_cyc = -1, done_cyc = -1, beat_n = 0, last_beat_cyc = 0;
  logic [31:0] miss_addr = '0;
  int          exp_cyc_q [$];
  logic [31:0] exp_dat_q [$];
  logic [31:0] resp_log [$];
  int          resp_cyc_log [$];
  int          acc_cyc_log [$];
  logic [31:0] last_mem_addr = '0;
  logic [31:0] last_tag_wdata = '0;
  int          n_gnt = 0, n_tagwr = 0;

  initial begin : compare
    int c;
    bit exp_ready, exp_rv, exp_mreq, exp_dwen;
    logic [6:0] idx;
    forever begin
      @(negedge clk);
      c = cyc;
      exp_ready = init_done && !busy;
      exp_mreq  = miss_on && !gnt_done && (c >= miss_cyc + 2);
      exp_dwen  = refill_on && mem_rvalid;
      if (prev_rst) begin
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  resp_data,       32'd0);
        check("rst_mem_req",    32'(mem_req),    32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_tag_wen",    32'(tag_wen),    32'd0);
        check("rst_tag_wdata",  32'(tag_wdata),  32'd0);
        check("rst_data_wen",   32'(data_wen),   32'd0);
      end else begin
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rv = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == c);
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
          check("resp_data", resp_data, exp_dat_q[0]);
          void'(exp_cyc_q.pop_front());
          void'(exp_dat_q.pop_front());
        end
        if (resp_valid) begin
          resp_log.push_back(resp_data);
          resp_cyc_log.push_back(c);
        end
        check("mem_req", 32'(mem_req), 32'(exp_mreq));
        if (exp_mreq) check("mem_addr", mem_addr, {miss_addr[31:5], 5'b0});
        if (c == tagwr_cyc) begin
          check("tag_wen", 32'(tag_wen), 32'hF);
          check("tag_wdata", 32'(tag_wdata), 32'({1'b1, miss_addr[31:12]}));
          check("tag_addr", tag_addr, miss_addr);
          last_tag_wdata = 32'(tag_wdata);
          cv[miss_addr[11:5]] = 1'b1;
          ct[miss_addr[11:5]] = miss_addr[31:12];
        end else begin
          check("tag_wen_idle", 32'(tag_wen), 32'd0);
        end
        if (tag_wen != 4'h0) n_tagwr++;
        check("data_wen", 32'(data_wen), 32'(exp_dwen));
        if (exp_dwen) begin
          check("data_addr", 32'(data_addr), 32'({miss_addr[11:5], 3'(beat_n)}));
          check("data_wdata", data_wdata, mem_rdata);
        end
      end

      // Advance the model with the inputs the next edge will sample
      if (exp_dwen) begin
        beat_n++;
        if (mem_rlast) begin
          refill_on = 0;
          last_beat_cyc = c;
          tagwr_cyc = c + 1;
          done_cyc  = c + 2;
          exp_cyc_q.push_back(c + 2);
          exp_dat_q.push_back(mem_word(miss_addr));
        end
      end
      if (exp_mreq && mem_gnt) begin
        gnt_done = 1; refill_on = 1; beat_n = 0;
        last_mem_addr = mem_addr;
        n_gnt++;
      end
      if (c == done_cyc) begin
        busy = 0; miss_on = 0;
      end
      if (req_valid && exp_ready) begin
        acc_cyc_log.push_back(c);
        idx = req_addr[11:5];
        if (cv[idx] && ct[idx] == req_addr[31:12]) begin
          exp_cyc_q.push_back(c + 1);
          exp_dat_q.push_back(mem_word(req_addr));
        end else begin
          miss_on = 1; busy = 1; gnt_done = 0; miss_cyc = c; miss_addr = req_addr;
        end
      end
      if (!init_done && tag_work) init_done = 1;
      if (rst) begin
        init_done = 0; busy = 0; miss_on = 0; gnt_done = 0; refill_on = 0;
        tagwr_cyc = -1; done_cyc = -1;
        exp_cyc_q.delete();
        exp_dat_q.delete();
      end
      prev_rst = rst;
    end
  end

  // Present a request and hold it until the DUT accepts it
  task automatic send(input logic [31:0] a);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 300) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom & 32'hFFFF_FFFC;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy && !miss_on && exp_cyc_q.size() == 0) break;
      t++;
      if (t > 500) begin
        check("quiet_timeout", 32'd1, 32'd0);
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  logic [19:0] tag_pool [3] = '{20'h00001, 20'h00002, 20'hBFC00};
  logic [6:0]  idx_pool [3] = '{7'd0, 7'd1, 7'd5};

  initial begin : stim
    int g0, r0, t0, t;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (130) @(posedge clk);
    #1 tag_work = 1'b1;
    @(negedge clk) check("init_hold", 32'(req_ready), 32'd0);
    @(negedge clk) check("init_release", 32'(req_ready), 32'd1);

    // Cold miss on the boot line
    g0 = n_gnt;
    send(32'hBFC0_0014); idle(0); wait_quiet();
    check("cold_mem_addr", last_mem_addr, 32'hBFC0_0000);
    check("cold_tag_wdata", last_tag_wdata, 32'h001B_FC00);
    check("cold_resp", resp_log[$], 32'h105);
    check("cold_latency", 32'(resp_cyc_log[$] - last_beat_cyc), 32'd2);
    check("cold_one_req", 32'(n_gnt - g0), 32'd1);

    // Repeat: hit
    g0 = n_gnt;
    send(32'hBFC0_0014); idle(0); wait_quiet();
    check("hit_resp", resp_log[$], 32'h105);
    check("hit_latency", 32'(resp_cyc_log[$] - acc_cyc_log[$]), 32'd1);
    check("hit_no_mem", 32'(n_gnt - g0), 32'd0);

    // Back-to-back hits
    r0 = resp_log.size();
    send(32'hBFC0_0000); send(32'hBFC0_0004); send(32'hBFC0_0008); idle(0); wait_quiet();
    check("b2b_count", 32'(resp_log.size() - r0), 32'd3);
    if (resp_log.size() - r0 == 3) begin
      for (int i = 0; i < 3; i++) check("b2b_data", resp_log[r0 + i], 32'h100 + 32'(i));
      check("b2b_span", 32'(resp_cyc_log[r0 + 2] - resp_cyc_log[r0]), 32'd2);
    end

    // Conflict miss then the evicted line misses
    send(32'hBFC0_1000); idle(0); wait_quiet();
    check("conf_tag_wdata", last_tag_wdata, 32'h001B_FC01);
    check("conf_resp", resp_log[$], mem_word(32'hBFC0_1000));
    g0 = n_gnt;
    send(32'hBFC0_0000); idle(0); wait_quiet();
    check("evicted_miss", 32'(n_gnt - g0), 32'd1);
    check("evicted_resp", resp_log[$], 32'h100);

    // Reset after three refill beats
    t0 = n_tagwr;
    beat_limit = 3;
    send(32'h0000_2468); idle(0);
    t = 0;
    while (!(refill_on && beat_n == 3) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("abort_beats_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    beat_limit = 8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("abort_no_tag", 32'(n_tagwr - t0), 32'd0);
    g0 = n_gnt;
    send(32'h0000_2468); idle(0); wait_quiet();
    check("abort_remiss", 32'(n_gnt - g0), 32'd1);
    check("abort_resp", resp_log[$], mem_word(32'h0000_2468));

    // Random traffic over a small set of lines
    for (int i = 0; i < 150; i++) begin
      a = {tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 2)],
           3'($urandom_range(0, 7)), 2'b00};
      send(a);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(0);
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
